// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined 16-bit carry-lookahead adder/subtractor with valid/ready
// handshake on both sides; stage 1 forms p/g and nibble GP/GG, stage 2 resolves carries.

module lac_unit (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       c0,
    output logic [3:0] c,
    output logic       cout
);
    // c[i] is the carry into bit i of the group.
    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    // Four nibbles feed exactly one second-level lookahead unit.
    localparam int NIB = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NIB-1:0]   gp;
        logic [NIB-1:0]   gg;
        logic             c0;
        logic             a_msb;
        logic             b_msb;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic             s1_valid, s2_valid;
    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] b_eff, p_in, g_in;
    logic [NIB-1:0]   gp_in, gg_in;
    s1_t              s1_d, s1_q;
    res_t             res_d, res_q;
    logic [NIB-1:0]   nib_c;
    logic             top_cout;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum_d;
    // Per-nibble carry-outs duplicate what the second-level unit already resolves.
    logic [NIB-1:0]   nib_co_unused;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    // ---------------- stage 1: condition operands, p/g, group P/G
    assign b_eff = sub ? ~b : b;
    assign p_in  = a ^ b_eff;
    assign g_in  = a & b_eff;

    genvar k;
    generate
        for (k = 0; k < NIB; k++) begin : g_grp
            assign gp_in[k] = &p_in[4*k +: 4];
            assign gg_in[k] = g_in[4*k+3]
                            | (p_in[4*k+3] & g_in[4*k+2])
                            | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                            | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
        end
    endgenerate

    always_comb begin
        s1_d       = '0;
        s1_d.p     = p_in;
        s1_d.g     = g_in;
        s1_d.gp    = gp_in;
        s1_d.gg    = gg_in;
        s1_d.c0    = sub ? 1'b1 : cin;
        s1_d.a_msb = a[WIDTH-1];
        s1_d.b_msb = b_eff[WIDTH-1];
    end

    // ---------------- stage 2: two-level carry tree, sum and flags
    lac_unit u_lac_top (
        .p    (s1_q.gp),
        .g    (s1_q.gg),
        .c0   (s1_q.c0),
        .c    (nib_c),
        .cout (top_cout)
    );

    generate
        for (k = 0; k < NIB; k++) begin : g_nib
            lac_unit u_lac (
                .p    (s1_q.p[4*k +: 4]),
                .g    (s1_q.g[4*k +: 4]),
                .c0   (nib_c[k]),
                .c    (c[4*k +: 4]),
                .cout (nib_co_unused[k])
            );
        end
    endgenerate

    assign sum_d = s1_q.p ^ c;

    always_comb begin
        res_d      = '0;
        res_d.sum  = sum_d;
        res_d.cout = top_cout;
        res_d.ovf  = (s1_q.a_msb == s1_q.b_msb) & (sum_d[WIDTH-1] != s1_q.a_msb);
        res_d.zero = ~|sum_d;
    end

    // ---------------- pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            res_q    <= '0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (in_valid && s1_adv) s1_q <= s1_d;
            if (s2_adv) s2_valid <= s1_valid;
            if (s1_valid && s2_adv) res_q <= res_d;
        end
    end

    assign out_valid = s2_valid;
    assign sum       = res_q.sum;
    assign cout      = res_q.cout;
    assign ovf       = res_q.ovf;
    assign zero      = res_q.zero;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corner vectors, reset mid-flight, backpressure,
// and a random stream scored against an integer-arithmetic model.

module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid, out_ready;
    logic [15:0] sum;
    logic        cout, ovf, zero;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    int   total = 0;
    int   bad = 0;
    int   fire_cnt = 0;
    res_t expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub);
        int   ua, ub, sa, sb, u, s;
        res_t r;
        ua = ma;
        ub = mb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (msub) begin
            u = ua - ub;
            s = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u = ua + ub + int'(mcin);
            s = sa + sb + int'(mcin);
            r.cout = (u > 65535);
        end
        r.sum  = u[15:0];
        r.ovf  = (s > 32767) || (s < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    // Scoreboard: accept pushes the expected beat, fire pops and compares.
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            chk("in_ready", in_ready, !(expq.size() == 2 && !out_ready));
            if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                fire_cnt++;
                chk("sb_nonempty", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("result", {sum, cout, ovf, zero}, e);
                end
            end
        end
    end

    task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tcin, input logic tsub, input logic [15:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_res"}, {sum, cout, ovf, zero}, {esum, ecout, eovf, ezero});
        @(posedge clk); #1;
    endtask

    initial begin
        int         k, cyc, fb, mid;
        logic       acc;
        logic [4:0] pat;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {out_valid, sum, cout, ovf, zero}, 0);
        chk("reset_rdy", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // Reset mid-flight with both stages full and output stalled.
        out_ready = 1'b0; in_valid = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'h3333;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_rdy", in_ready, 0);
        chk("full_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {out_valid, sum, cout, ovf, zero}, 0);
        expq.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_stale", out_valid, 0);
        end

        // Backpressure: beats k=1..5, out_ready pattern 1,0,0,1,1 repeating.
        pat = 5'b11001;
        k = 1; cyc = 0; fb = fire_cnt;
        while (k <= 5 && cyc < 100) begin
            out_ready = pat[cyc % 5];
            a = 16'(k); b = 16'(k); cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        chk("bp_sent", k, 6);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 20 && expq.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("bp_drain", expq.size(), 0);
        chk("bp_count", fire_cnt - fb, 5);

        // Random streaming at full throughput.
        @(posedge clk); #1;
        fb = fire_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        mid = fire_cnt;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("steady", mid - fb, 998);
        chk("thruput", fire_cnt - fb, 1000);
        chk("rand_drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
